// File: rtl/tent_pkg.sv
// Shared constants and types for the tent-map channel scheduler.
package tent_pkg;

  localparam int TENT_W   = 16;
  localparam int TENT_NCH = 4;

  // Fold point and top of the 16-bit tent map.
  localparam logic [15:0] TENT_HALF = 16'h8000;
  localparam logic [15:0] TENT_MAX  = 16'hFFFF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tent_state_e;

endpackage

// File: rtl/tent_step.sv
// One tent-map iteration: y = mu * x below the fold, mu * (MAX - x) above it.
module tent_step
  import tent_pkg::*;
#(
  parameter int W = TENT_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] mu,
  output logic [W-1:0] y
);

  // At the default width these are exactly TENT_HALF / TENT_MAX.
  localparam logic [W-1:0] HALF = (W == TENT_W) ? W'(TENT_HALF) : (W'(1) << (W - 1));
  localparam logic [W-1:0] MAX  = (W == TENT_W) ? W'(TENT_MAX) : {W{1'b1}};

  logic [W-1:0] operand;

  // Mirror x about the fold, then keep the low W bits of the product (wraps, no saturation).
  always_comb begin
    operand = (x < HALF) ? x : (MAX - x);
    y       = mu * operand;
  end

endmodule

// File: rtl/tent_scheduler.sv
// NCH independent tent-map channels time-sharing one tent_step datapath,
// granted round-robin among channels in RUN.
//
// state | meaning
// IDLE  | waiting for start; x holds the last result
// RUN   | iterating; advances x once per grant until rem reaches 0
module tent_scheduler
  import tent_pkg::*;
#(
  parameter int NCH = TENT_NCH,
  parameter int W   = TENT_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [NCH-1:0]   start,
  input  logic [NCH*W-1:0] dzero,
  input  logic [NCH*W-1:0] times,
  input  logic [NCH*W-1:0] mu,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   done,
  output logic [NCH*W-1:0] result
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  tent_state_e      state_q [NCH];
  tent_state_e      state_d [NCH];
  logic [W-1:0]     x_q     [NCH];
  logic [W-1:0]     x_d     [NCH];
  logic [W-1:0]     rem_q   [NCH];
  logic [W-1:0]     rem_d   [NCH];
  logic [W-1:0]     mu_q    [NCH];
  logic [W-1:0]     mu_d    [NCH];
  logic [NCH-1:0]   done_q;
  logic [NCH-1:0]   done_d;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    ptr_d;

  logic             gnt_vld;
  logic [IW-1:0]    gnt_idx;
  logic [W-1:0]     step_x;
  logic [W-1:0]     step_mu;
  logic [W-1:0]     step_y;

  // Round-robin pick: first RUN channel at or after ptr_q, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!gnt_vld && state_q[(int'(ptr_q) + k) % NCH] == RUN) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'((int'(ptr_q) + k) % NCH);
      end
    end
  end

  assign step_x  = x_q[gnt_idx];
  assign step_mu = mu_q[gnt_idx];

  tent_step #(.W(W)) u_tent_step (
    .x  (step_x),
    .mu (step_mu),
    .y  (step_y)
  );

  // Next state: accept starts on idle channels, advance the granted channel.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    rem_d   = rem_q;
    mu_d    = mu_q;
    done_d  = '0;
    ptr_d   = ptr_q;

    for (int c = 0; c < NCH; c++) begin
      if (state_q[c] == IDLE && start[c]) begin
        x_d[c]   = dzero[c*W +: W];
        mu_d[c]  = mu[c*W +: W];
        rem_d[c] = times[c*W +: W];
        if (times[c*W +: W] != '0) begin
          state_d[c] = RUN;
        end else begin
          done_d[c] = 1'b1;
        end
      end
    end

    // The granted channel is in RUN, so it never collides with a start above.
    if (gnt_vld) begin
      x_d[gnt_idx]   = step_y;
      rem_d[gnt_idx] = rem_q[gnt_idx] - W'(1);
      if (rem_q[gnt_idx] == W'(1)) begin
        state_d[gnt_idx] = IDLE;
        done_d[gnt_idx]  = 1'b1;
      end
      ptr_d = (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= IDLE;
        x_q[c]     <= '0;
        rem_q[c]   <= '0;
        mu_q[c]    <= '0;
      end
      done_q <= '0;
      ptr_q  <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= state_d[c];
        x_q[c]     <= x_d[c];
        rem_q[c]   <= rem_d[c];
        mu_q[c]    <= mu_d[c];
      end
      done_q <= done_d;
      ptr_q  <= ptr_d;
    end
  end

  // Flatten per-channel state onto the output buses.
  always_comb begin
    busy   = '0;
    result = '0;
    for (int c = 0; c < NCH; c++) begin
      busy[c]           = (state_q[c] == RUN);
      result[c*W +: W]  = x_q[c];
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_tent_scheduler.sv
// Bench for tent_scheduler: table of single-channel runs, hand sequences for
// round-robin / restart / reset, and a random phase against a behavioural model.
module tb_tent_scheduler;

  localparam int NCH = 4;
  localparam int W   = 16;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic [NCH-1:0]   start;
  logic [NCH*W-1:0] dzero;
  logic [NCH*W-1:0] times;
  logic [NCH*W-1:0] mu;
  logic [NCH-1:0]   busy;
  logic [NCH-1:0]   done;
  logic [NCH*W-1:0] result;

  tent_scheduler #(.NCH(NCH), .W(W)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .start  (start),
    .dzero  (dzero),
    .times  (times),
    .mu     (mu),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: per-channel running flag, value, remaining count, slope.
  bit             m_run [NCH];
  int             m_x   [NCH];
  int             m_rem [NCH];
  int             m_mu  [NCH];
  int             m_ptr;
  bit [NCH-1:0]   m_done;

  function automatic int tent(int x, int m);
    longint p;
    if (x < 32768) p = longint'(m) * longint'(x);
    else           p = longint'(m) * longint'(65535 - x);
    return int'(p % 65536);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_run[c] = 0; m_x[c] = 0; m_rem[c] = 0; m_mu[c] = 0;
    end
    m_ptr  = 0;
    m_done = '0;
  endtask

  // Apply the spec rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    int gnt;
    gnt = -1;
    for (int k = 0; k < NCH; k++)
      if (gnt < 0 && m_run[(m_ptr + k) % NCH]) gnt = (m_ptr + k) % NCH;
    m_done = '0;
    for (int c = 0; c < NCH; c++) begin
      if (!m_run[c] && start[c]) begin
        m_x[c]   = int'(dzero[c*W +: W]);
        m_mu[c]  = int'(mu[c*W +: W]);
        m_rem[c] = int'(times[c*W +: W]);
        if (m_rem[c] != 0) m_run[c] = 1;
        else               m_done[c] = 1;
      end
    end
    if (gnt >= 0) begin
      m_x[gnt]   = tent(m_x[gnt], m_mu[gnt]);
      m_rem[gnt] = m_rem[gnt] - 1;
      if (m_rem[gnt] == 0) begin
        m_run[gnt]  = 0;
        m_done[gnt] = 1;
      end
      m_ptr = (gnt + 1) % NCH;
    end
  endtask

  task automatic model_check();
    logic [NCH-1:0]   eb;
    logic [NCH*W-1:0] er;
    for (int c = 0; c < NCH; c++) begin
      eb[c]          = m_run[c];
      er[c*W +: W]   = m_x[c][W-1:0];
    end
    check("model_busy", 64'(busy), 64'(eb));
    check("model_done", 64'(done), 64'(m_done));
    check("model_result", 64'(result), 64'(er));
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
    model_check();
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    start = '0;
    #1;
    model_reset();
    model_check();
    @(negedge CLK);
    RST_N = 1'b1;
    step();
  endtask

  typedef struct {
    logic [15:0] dz;
    logic [15:0] m;
    logic [15:0] t;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl [8];
  logic [15:0] exp28 [3];
  logic [NCH*W-1:0] prev;
  int          n;
  int          chg;

  initial begin
    tbl[0] = '{16'h1000, 16'h0002, 16'd3, 16'h8000};
    tbl[1] = '{16'h9000, 16'h0002, 16'd1, 16'hDFFE};
    tbl[2] = '{16'h0100, 16'h0100, 16'd1, 16'h0000};
    tbl[3] = '{16'h1234, 16'h0005, 16'd0, 16'h1234};
    tbl[4] = '{16'h8000, 16'h0001, 16'd1, 16'h7FFF};
    tbl[5] = '{16'h7FFF, 16'h0001, 16'd1, 16'h7FFF};
    tbl[6] = '{16'h0003, 16'h0003, 16'd2, 16'h001B};
    tbl[7] = '{16'hFFFF, 16'h0005, 16'd2, 16'h0000};
    exp28[0] = 16'h2000; exp28[1] = 16'h4000; exp28[2] = 16'h8000;

    start = '0; dzero = '0; times = '0; mu = '0;
    @(posedge CLK); #1;
    do_reset();
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_result", 64'(result), 64'(0));

    // Single-channel table on ch0.
    for (int i = 0; i < 8; i++) begin
      start = 4'b0001;
      dzero[15:0] = tbl[i].dz;
      mu[15:0]    = tbl[i].m;
      times[15:0] = tbl[i].t;
      step();
      start = '0;
      n = 0;
      while (!done[0] && n < 40) begin
        step();
        n++;
      end
      check("tbl_done_latency", 64'(n), 64'(tbl[i].t));
      check("tbl_done_high", 64'(done[0]), 64'(1));
      check("tbl_result", 64'(result[15:0]), 64'(tbl[i].exp));
      step();
      check("tbl_done_one_cycle", 64'(done[0]), 64'(0));
      check("tbl_result_hold", 64'(result[15:0]), 64'(tbl[i].exp));
      check("tbl_idle", 64'(busy[0]), 64'(0));
    end

    // Ch0 intermediate values 0x2000, 0x4000, 0x8000.
    start = 4'b0001;
    dzero[15:0] = 16'h1000; mu[15:0] = 16'h0002; times[15:0] = 16'd3;
    step();
    start = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("seq_iter_value", 64'(result[15:0]), 64'(exp28[k]));
      check("seq_done", 64'(done[0]), 64'(k == 2));
    end

    // All four channels together: grants 0,1,2,3,0,1,2,3.
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      dzero[c*W +: W] = 16'h0010 + 16'(c);
      mu[c*W +: W]    = 16'h0003;
      times[c*W +: W] = 16'd2;
    end
    start = 4'b1111;
    step();
    start = '0;
    check("rr_all_busy", 64'(busy), 64'(4'b1111));
    prev = result;
    for (int k = 0; k < 8; k++) begin
      step();
      chg = -1;
      for (int c = 0; c < NCH; c++)
        if (result[c*W +: W] != prev[c*W +: W]) chg = (chg < 0) ? c : 99;
      check("rr_grant", 64'(chg), 64'(k % 4));
      check("rr_done", 64'(done), 64'((k >= 4) ? (1 << (k - 4)) : 0));
      prev = result;
    end

    // Restart of a busy channel is ignored.
    do_reset();
    dzero[16 +: 16] = 16'h0100; mu[16 +: 16] = 16'h0002; times[16 +: 16] = 16'd5;
    start = 4'b0010;
    step();
    start = '0;
    step();
    step();
    dzero[16 +: 16] = 16'hAAAA; mu[16 +: 16] = 16'h0007; times[16 +: 16] = 16'd1;
    start = 4'b0010;
    step();
    start = '0;
    check("restart_still_busy", 64'(busy[1]), 64'(1));
    check("restart_value", 64'(result[16 +: 16]), 64'(16'h0800));
    n = 0;
    while (!done[1] && n < 20) begin
      step();
      n++;
    end
    check("restart_done_wait", 64'(n), 64'(2));
    check("restart_final", 64'(result[16 +: 16]), 64'(16'h2000));

    // Reset in the middle of a run.
    dzero = '0; mu = '0; times = '0;
    dzero[0 +: 16] = 16'h0001; mu[0 +: 16] = 16'h0002; times[0 +: 16] = 16'd10;
    dzero[32 +: 16] = 16'h0005; mu[32 +: 16] = 16'h0002; times[32 +: 16] = 16'd10;
    start = 4'b0101;
    step();
    start = '0;
    step();
    step();
    #2;
    RST_N = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_result", 64'(result), 64'(0));
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      check("midrst_no_done", 64'(done), 64'(0));
    end

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < NCH; c++) begin
        start[c]        = ($urandom_range(0, 3) == 0);
        dzero[c*W +: W] = 16'($urandom);
        mu[c*W +: W]    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4));
        times[c*W +: W] = 16'($urandom_range(0, 6));
      end
      step();
    end
    start = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tent_scheduler.md
TENT_SCHEDULER -- requirements
Module: tent_scheduler

Interface
REQ-001 The block SHALL have parameter NCH, default 4, giving the number of independent tent-map channels sharing one datapath.
REQ-002 The block SHALL have parameter W, default 16, giving the data, mu and iteration-count width.
REQ-003 The block SHALL have port CLK, input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, NCH bits, per-channel start request, sampled on CLK.
REQ-006 The block SHALL have port dzero, input, NCH*W bits, per-channel initial value, slice c = bits [c*W +: W].
REQ-007 The block SHALL have port times, input, NCH*W bits, per-channel iteration count.
REQ-008 The block SHALL have port mu, input, NCH*W bits, per-channel tent slope.
REQ-009 The block SHALL have port busy, output, NCH bits, high while a channel is in RUN.
REQ-010 The block SHALL have port done, output, NCH bits, one-cycle completion pulse per channel.
REQ-011 The block SHALL have port result, output, NCH*W bits, per-channel current state value x.

Function
REQ-012 Each channel SHALL hold state IDLE or RUN, plus registers x (W), rem (W), mu_q (W).
REQ-013 In IDLE with start[c]=1 at an edge: x<=dzero, mu_q<=mu, rem<=times; if times!=0 go RUN, else stay IDLE and assert done[c] at that edge.
REQ-014 start[c] while channel c is in RUN SHALL be ignored; dzero, times and mu of that channel SHALL not be resampled.
REQ-015 Each cycle exactly one RUN channel, if any, SHALL be granted the single shared tent datapath.
REQ-016 The grant SHALL be round-robin: search starts at the channel after the last granted one, wrapping NCH-1 to 0; the pointer updates only on a grant.
REQ-017 A channel entering RUN at edge E SHALL first be eligible for grant in the cycle after E.
REQ-018 The tent step SHALL compute y = (x < 0x8000) ? mu_q*x : mu_q*(0xFFFF - x), full 2W-bit product, y = low W bits (modulo 2^W, no saturation).
REQ-019 On the granted edge: x<=y, rem<=rem-1; if rem was 1, channel goes IDLE and done[c] is asserted at that same edge, coinciding with the final result.
REQ-020 done[c] SHALL be high for exactly one cycle per completion; busy[c] SHALL equal (state==RUN).
REQ-021 result[c] SHALL hold x continuously and remain stable in IDLE until the next accepted start.
REQ-022 A lone channel with times=T>=1 started at edge E0 SHALL write iterations at E1..ET, with done high in the cycle after ET; with k channels in RUN, each SHALL advance once per k cycles.
REQ-023 Independent starts on several channels in the same cycle SHALL all be accepted.

Reset
REQ-024 RST_N low SHALL immediately, without a clock, force all channels IDLE, x/rem/mu_q=0, busy=0, done=0, and the round-robin pointer=0.
REQ-025 Reset asserted mid-run SHALL abandon all iterations; no done SHALL follow reset release.

Structure
REQ-026 Package tent_pkg SHALL hold W and NCH defaults, TENT_HALF=0x8000, TENT_MAX=0xFFFF and the channel-state enum {IDLE, RUN}.
REQ-027 The tent arithmetic SHALL be one combinational sub-module tent_step (x, mu -> y), instantiated exactly once.

Verification
REQ-028 Ch0 dzero=0x1000, mu=0x0002, times=3 -> x 0x2000, 0x4000, 0x8000 on E1..E3; done[0] pulses once; result[0]=0x8000.
REQ-029 Fold branch: dzero=0x9000, mu=0x0002, times=1 -> result=0xDFFE; overflow: dzero=0x0100, mu=0x0100, times=1 -> result=0x0000.
REQ-030 times=0, dzero=0x1234 -> busy never high; done pulses in the cycle after start; result=0x1234.
REQ-031 All four channels started in the same cycle with times=2 -> grants 0,1,2,3,0,1,2,3; done[0..3] pulse on four consecutive cycles.
REQ-032 Re-start ch1 while busy with different dzero -> ignored, result unchanged by new inputs; RST_N pulse mid-run -> all outputs 0, no later done.
